// File: rtl/mem_req_queue.sv
// In-order request FIFO feeding a single-outstanding memory handshake master,
// with a one-entry read response register and per-type completion counters.
module mem_req_queue #(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int QDEPTH     = 4,
    parameter int CW         = $clog2(QDEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr_rd,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [WIDTH-1:0]      req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [WIDTH-1:0]      rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  valid,
    output logic                  wr_rd,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wdata,
    input  logic [WIDTH-1:0]      rdata,
    input  logic                  ready,
    output logic [CW-1:0]         q_count,
    output logic [15:0]           wr_done_cnt,
    output logic [15:0]           rd_done_cnt
);
    localparam int PW = $clog2(QDEPTH);

    typedef struct packed {
        logic                  wr_rd;
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      wdata;
    } req_t;

    typedef enum logic {IDLE, BUSY} state_t;

    req_t                  fifo_q [QDEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    state_t                state_q, state_d;
    logic                  valid_q, valid_d;
    logic                  wr_rd_q, wr_rd_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0]      wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]      rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_WIDTH-1:0] rsp_addr_q, rsp_addr_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;

    logic push, pop, done, slot_busy, can_issue;
    req_t head;

    assign req_ready = (count_q != CW'(QDEPTH));

    always_comb begin
        push = req_valid && req_ready;
        done = valid_q && ready;
        head = fifo_q[rd_ptr_q];
        // The slot is taken after this edge if the held response is not popped
        // or the read completing right now is about to land in it.
        slot_busy = (rsp_valid_q && !rsp_ready) || (done && !wr_rd_q);
        can_issue = (count_q != '0) && (head.wr_rd || !slot_busy);
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        wr_rd_d = wr_rd_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (can_issue) begin
                    pop     = 1'b1;
                    valid_d = 1'b1;
                    wr_rd_d = head.wr_rd;
                    addr_d  = head.addr;
                    wdata_d = head.wdata;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    if (can_issue) begin
                        pop     = 1'b1;
                        wr_rd_d = head.wr_rd;
                        addr_d  = head.addr;
                        wdata_d = head.wdata;
                    end else begin
                        valid_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);
        count_d     = count_q + CW'(push) - CW'(pop);
        rsp_valid_d = rsp_valid_q && !rsp_ready;
        rsp_rdata_d = rsp_rdata_q;
        rsp_addr_d  = rsp_addr_q;
        if (done && !wr_rd_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata;
            rsp_addr_d  = addr_q;
        end
        wr_cnt_d = wr_cnt_q + 16'(done && wr_rd_q);
        rd_cnt_d = rd_cnt_q + 16'(done && !wr_rd_q);
    end

    // Entry storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{wr_rd: req_wr_rd, addr: req_addr, wdata: req_wdata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            wr_rd_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_addr_q  <= '0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            valid_q     <= valid_d;
            wr_rd_q     <= wr_rd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_addr_q  <= rsp_addr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
        end
    end

    assign valid       = valid_q;
    assign wr_rd       = wr_rd_q;
    assign addr        = addr_q;
    assign wdata       = wdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_addr    = rsp_addr_q;
    assign q_count     = count_q;
    assign wr_done_cnt = wr_cnt_q;
    assign rd_done_cnt = rd_cnt_q;
endmodule

// File: doc/mem_req_queue.md
# mem_req_queue

Request queue and handshake master sitting directly upstream of the memory block. It accepts write/read requests from a client port into an in-order FIFO, drives the memory's valid/wr_rd/addr/wdata handshake one transaction at a time, and returns read data through a single-entry response register with backpressure. Per-type completion counters let the bench and scoreboard tally finished transactions without probing the memory.

## Interface
- WIDTH, 16, data width; must match the memory's WIDTH.
- DEPTH, 16, memory depth; informational only, ADDR_WIDTH = $clog2(DEPTH).
- ADDR_WIDTH, 4, address width; must match the memory.
- QDEPTH, 4, request FIFO entries; power of two, at least 2.
- CW, $clog2(QDEPTH+1), width of q_count.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset; asserting it clears all state immediately.
- req_valid  in  1  client request present.
- req_ready  out  1  queue can accept; high when not full.
- req_wr_rd  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  request address.
- req_wdata  in  WIDTH  write data; ignored for reads.
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  client consumes the response.
- rsp_rdata  out  WIDTH  read data.
- rsp_addr  out  ADDR_WIDTH  address of the read.
- valid  out  1  memory request valid.
- wr_rd  out  1  memory write/read select.
- addr  out  ADDR_WIDTH  memory address.
- wdata  out  WIDTH  memory write data.
- rdata  in  WIDTH  memory read data; sampled on the completing edge.
- ready  in  1  memory ready.
- q_count  out  CW  FIFO occupancy.
- wr_done_cnt  out  16  completed writes; wraps at 0xFFFF to 0.
- rd_done_cnt  out  16  completed reads; wraps at 0xFFFF to 0.

## Operation
- Handshakes:
  - A request is pushed on an edge where req_valid && req_ready.
  - A memory transaction completes on an edge where valid && ready.
  - A response is popped on an edge where rsp_valid && rsp_ready.
- FIFO ordering:
  - Strictly in-order, no bypass. A pushed entry is eligible for issue starting the cycle after the push.
  - req_ready = (q_count != QDEPTH). A full queue does not accept even if a pop occurs in the same cycle.
- Memory-side FSM, IDLE and BUSY:
  - IDLE: if the FIFO is non-empty and the head is issuable, load the head into the addr/wdata/wr_rd registers, pop it, set valid = 1, and go to BUSY.
  - BUSY: the outputs are held stable until completion.
    - On completion, if the next head is issuable, load it on the same edge and stay in BUSY. valid stays high, giving back-to-back transfers.
    - Otherwise set valid = 0 and return to IDLE.
- Issuable head:
  - A write is always issuable.
  - A read is issuable only when the response slot will be free: rsp_valid == 0, or rsp_valid && rsp_ready in that cycle.
  - A blocked read at the head stalls all younger entries.
- Read completion: the completing edge captures rdata and addr into rsp_rdata/rsp_addr and sets rsp_valid. rsp_valid stays high until popped.
- Completion counters: wr_done_cnt increments on write completion, rd_done_cnt on read completion.
- Simultaneous events:
  - Push and issue-pop in the same cycle leave q_count unchanged.
  - Response pop and a new read capture in the same edge leave rsp_valid = 1 with the new data.
- Reset, including mid-transaction:
  - All outputs go to 0 immediately: valid, wr_rd, addr, wdata, rsp_valid, rsp_rdata, rsp_addr, q_count, both counters, and the FSM (IDLE).
  - req_ready goes to 1 once the queue is empty.
  - In-flight and queued requests are discarded.

## Timing
- Issue latency: push at edge N, valid high after edge N+1, provided the FSM is IDLE and the head is issuable.
- Completion: with ready already high, the transaction completes at edge N+2 and rsp_valid is high after N+2.
- Sustained throughput: one transaction per cycle while ready stays high and no read is blocked.
- valid never drops before completion. addr/wdata/wr_rd never change while valid && !ready.
- q_count updates on the push/pop edge. Counters update on the completion edge.

## Test plan
- Reset: hold rst = 0 while driving requests, then release.
  - All outputs read 0 and req_ready = 1.
  - rst is asserted mid-BUSY with valid = 1: valid drops in the same time step and q_count = 0.
- Write then read:
  - Write addr 3 data 0xA5A5, then read addr 3, with memory ready tied high.
  - Required: wr_done_cnt = 1, rd_done_cnt = 1, rsp_rdata = 0xA5A5, rsp_addr = 3. rsp_valid is first high 2 edges after the read is pushed, provided the queue was otherwise empty.
- Full queue:
  - With ready held low, push 5 writes into QDEPTH = 4. The first is issued and the next 4 fill the queue.
  - Required: req_ready = 0 with q_count = 4; the 6th request is not accepted.
  - Release ready: 5 completions on consecutive edges.
- Response backpressure:
  - With rsp_ready = 0, issue read addr 1 then read addr 2.
  - Required: the second read is not issued (valid low, q_count = 1) until rsp_ready pulses. The first response stays stable throughout.
- Stall stability: toggle ready randomly during 16 mixed transactions.
  - Required: addr/wdata/wr_rd stay constant while valid && !ready.
  - Every read returns the last value written to its address.
  - wr_done_cnt + rd_done_cnt = 16.
- Counter wrap: preload wr_done_cnt to 0xFFFF via 65535 writes (or force it), then complete one write; wr_done_cnt reads 0.
